posit_mult_core: RTL and testbench

- Multiply stage directly downstream of posit field extraction.
- Consumes two extracted operands (sign, k, exponent, mantissa, inf, zero) and computes:
  - result sign;
  - combined scale, k·2^ES + exponent, for each operand and summed;
  - normalised N-bit product mantissa with sticky.
- The mantissa multiply is iterative shift-add; output feeds the posit rounding/encoding stage.
- Valid/ready handshake on both sides.

---
 rtl/posit_mult_pkg.sv | 22 ++
 rtl/posit_mult_if.sv | 48 ++++
 rtl/posit_mant_mul_iter.sv | 99 +++++++++
 rtl/posit_mult_core.sv | 149 ++++++++++++++
 tb/tb_posit_mult_core.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/posit_mult_pkg.sv
// Shared types and constants for the posit multiply stage.
// POSIT_MULT_RADIX4_EN selects two multiplier bits per iteration.
package posit_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int scale_w(input int rs, input int es);
        return rs + es + 4;
    endfunction

`ifdef POSIT_MULT_RADIX4_EN
    localparam int RADIX_STEP = 2;
`else
    localparam int RADIX_STEP = 1;
`endif

endpackage

// File: rtl/posit_mult_if.sv
// Operand/result handshake bundle for posit_mult_core.
// slave = core side, master = upstream/downstream environment side.
interface posit_mult_if #(
    parameter int N  = 8,
    parameter int ES = 3,
    parameter int RS = $clog2(N)
);
    localparam int SW = posit_mult_pkg::scale_w(RS, ES);

    logic                 in_valid;
    logic                 in_ready;
    logic                 a_sign;
    logic                 b_sign;
    logic signed [RS+1:0] a_k;
    logic signed [RS+1:0] b_k;
    logic [ES-1:0]        a_exp;
    logic [ES-1:0]        b_exp;
    logic [N-1:0]         a_mant;
    logic [N-1:0]         b_mant;
    logic                 a_inf;
    logic                 b_inf;
    logic                 a_zero;
    logic                 b_zero;

    logic                 out_valid;
    logic                 out_ready;
    logic                 out_sign;
    logic signed [SW-1:0] out_scale;
    logic [N-1:0]         out_mant;
    logic                 out_sticky;
    logic                 out_inf;
    logic                 out_zero;

    modport slave (
        input  in_valid, a_sign, b_sign, a_k, b_k, a_exp, b_exp,
               a_mant, b_mant, a_inf, b_inf, a_zero, b_zero, out_ready,
        output in_ready, out_valid, out_sign, out_scale, out_mant,
               out_sticky, out_inf, out_zero
    );

    modport master (
        output in_valid, a_sign, b_sign, a_k, b_k, a_exp, b_exp,
               a_mant, b_mant, a_inf, b_inf, a_zero, b_zero, out_ready,
        input  in_ready, out_valid, out_sign, out_scale, out_mant,
               out_sticky, out_inf, out_zero
    );

endinterface

// File: rtl/posit_mant_mul_iter.sv
// Iterative shift-add mantissa multiplier producing a 2N-bit product.
// POSIT_MULT_RADIX4_EN retires two multiplier bits per cycle using a precomputed 3x multiplicand.
module posit_mant_mul_iter
    import posit_mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           start,
    input  logic [N-1:0]   a_mant,
    input  logic [N-1:0]   b_mant,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_INIT = CW'(N / RADIX_STEP - 1);

    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
`ifdef POSIT_MULT_RADIX4_EN
    logic [2*N-1:0] mcand3_q, mcand3_d;
`endif

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
`ifdef POSIT_MULT_RADIX4_EN
        mcand3_d = mcand3_q;
`endif
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{N{1'b0}}, a_mant};
            mplier_d = b_mant;
            cnt_d    = CNT_INIT;
            busy_d   = 1'b1;
`ifdef POSIT_MULT_RADIX4_EN
            mcand3_d = {{N{1'b0}}, a_mant} + {{(N-1){1'b0}}, a_mant, 1'b0};
`endif
        end else if (busy_q) begin
`ifdef POSIT_MULT_RADIX4_EN
            unique case (mplier_q[1:0])
                2'd1:    acc_d = acc_q + mcand_q;
                2'd2:    acc_d = acc_q + {mcand_q[2*N-2:0], 1'b0};
                2'd3:    acc_d = acc_q + mcand3_q;
                default: acc_d = acc_q;
            endcase
            mplier_d = mplier_q >> 2;
            mcand_d  = mcand_q << 2;
            mcand3_d = mcand3_q << 2;
`else
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mplier_d = mplier_q >> 1;
            mcand_d  = mcand_q << 1;
`endif
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
`ifdef POSIT_MULT_RADIX4_EN
            mcand3_q <= '0;
`endif
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
`ifdef POSIT_MULT_RADIX4_EN
            mcand3_q <= mcand3_d;
`endif
        end
    end

    // done marks the final step; product is complete after this edge
    assign done    = busy_q && (cnt_q == '0);
    assign product = acc_q;

endmodule

// File: rtl/posit_mult_core.sv
// Posit multiply stage: sign, combined scale and normalised mantissa with sticky.
// Iteration radix is set by POSIT_MULT_RADIX4_EN (see posit_mult_pkg).
module posit_mult_core
    import posit_mult_pkg::*;
#(
    parameter int N  = 8,
    parameter int ES = 3,
    parameter int RS = $clog2(N)
) (
    input  logic         clk,
    input  logic         nrst,
    posit_mult_if.slave  bus
);

    // state | meaning
    // IDLE  | ready for an operand pair
    // BUSY  | iterative mantissa multiply running
    // NORM  | normalise product, register results
    // DONE  | result presented until out_ready

    localparam int SW = scale_w(RS, ES);

    state_e               state_q, state_d;
    logic                 sign_q, sign_d;
    logic signed [SW-1:0] scale_q, scale_d;
    logic                 out_sign_q, out_sign_d;
    logic signed [SW-1:0] out_scale_q, out_scale_d;
    logic [N-1:0]         out_mant_q, out_mant_d;
    logic                 out_sticky_q, out_sticky_d;
    logic                 out_inf_q, out_inf_d;
    logic                 out_zero_q, out_zero_d;

    logic                 mul_start;
    logic                 mul_done;
    logic [2*N-1:0]       prod;
    logic signed [SW-1:0] a_sc, b_sc;
    logic                 any_inf, any_zero;

    posit_mant_mul_iter #(.N(N)) u_mul (
        .clk     (clk),
        .nrst    (nrst),
        .start   (mul_start),
        .a_mant  (bus.a_mant),
        .b_mant  (bus.b_mant),
        .done    (mul_done),
        .product (prod)
    );

    // scale = k * 2^ES + exp, k sign-extended before the shift
    assign a_sc = ({{(SW-RS-2){bus.a_k[RS+1]}}, bus.a_k} <<< ES) + {{(SW-ES){1'b0}}, bus.a_exp};
    assign b_sc = ({{(SW-RS-2){bus.b_k[RS+1]}}, bus.b_k} <<< ES) + {{(SW-ES){1'b0}}, bus.b_exp};
    assign any_inf  = bus.a_inf | bus.b_inf;
    assign any_zero = bus.a_zero | bus.b_zero;

    always_comb begin
        state_d      = state_q;
        sign_d       = sign_q;
        scale_d      = scale_q;
        out_sign_d   = out_sign_q;
        out_scale_d  = out_scale_q;
        out_mant_d   = out_mant_q;
        out_sticky_d = out_sticky_q;
        out_inf_d    = out_inf_q;
        out_zero_d   = out_zero_q;
        mul_start    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = bus.a_sign ^ bus.b_sign;
                    scale_d = a_sc + b_sc;
                    if (any_inf || any_zero) begin
                        // inf dominates zero, so inf x 0 reports NaR
                        out_sign_d   = 1'b0;
                        out_scale_d  = '0;
                        out_mant_d   = '0;
                        out_sticky_d = 1'b0;
                        out_inf_d    = any_inf;
                        out_zero_d   = !any_inf;
                        state_d      = DONE;
                    end else begin
                        mul_start = 1'b1;
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                if (mul_done) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                out_sign_d = sign_q;
                out_inf_d  = 1'b0;
                out_zero_d = 1'b0;
                if (prod[2*N-1]) begin
                    out_mant_d   = prod[2*N-1:N];
                    out_sticky_d = |prod[N-1:0];
                    out_scale_d  = scale_q + SW'(1);
                end else begin
                    out_mant_d   = prod[2*N-2:N-1];
                    out_sticky_d = |prod[N-2:0];
                    out_scale_d  = scale_q;
                end
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            sign_q       <= 1'b0;
            scale_q      <= '0;
            out_sign_q   <= 1'b0;
            out_scale_q  <= '0;
            out_mant_q   <= '0;
            out_sticky_q <= 1'b0;
            out_inf_q    <= 1'b0;
            out_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sign_q       <= sign_d;
            scale_q      <= scale_d;
            out_sign_q   <= out_sign_d;
            out_scale_q  <= out_scale_d;
            out_mant_q   <= out_mant_d;
            out_sticky_q <= out_sticky_d;
            out_inf_q    <= out_inf_d;
            out_zero_q   <= out_zero_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_sign   = out_sign_q;
    assign bus.out_scale  = out_scale_q;
    assign bus.out_mant   = out_mant_q;
    assign bus.out_sticky = out_sticky_q;
    assign bus.out_inf    = out_inf_q;
    assign bus.out_zero   = out_zero_q;

endmodule

// File: tb/tb_posit_mult_core.sv
// Directed bench for posit_mult_core (N=8, ES=3) with hand-computed expectations.
// Normal-operand latency follows POSIT_MULT_RADIX4_EN when the bench is built with it.
module tb_posit_mult_core;

    localparam int N  = 8;
    localparam int ES = 3;
    localparam int RS = 3;
    localparam int KW = RS + 2;
`ifdef POSIT_MULT_RADIX4_EN
    localparam int LAT = N / 2 + 1;
`else
    localparam int LAT = N + 1;
`endif

    logic clk;
    logic nrst;
    int   checks;
    int   failures;

    posit_mult_if #(.N(N), .ES(ES), .RS(RS)) bus ();

    posit_mult_core #(.N(N), .ES(ES), .RS(RS)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_a(input logic s, input int k, input int e, input logic [7:0] m,
                         input logic inf, input logic zero);
        bus.a_sign = s;
        bus.a_k    = KW'(k);
        bus.a_exp  = ES'(e);
        bus.a_mant = m;
        bus.a_inf  = inf;
        bus.a_zero = zero;
    endtask

    task automatic set_b(input logic s, input int k, input int e, input logic [7:0] m,
                         input logic inf, input logic zero);
        bus.b_sign = s;
        bus.b_k    = KW'(k);
        bus.b_exp  = ES'(e);
        bus.b_mant = m;
        bus.b_inf  = inf;
        bus.b_zero = zero;
    endtask

    // accept at edge 0, then expect out_valid to appear exactly after edge lat
    task automatic issue(input string tag, input int lat, input bit hold);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold) bus.in_valid = 1'b0;
        chk({tag, "_in_ready_busy"}, 16'(bus.in_ready), 16'd0);
        for (int e = 1; e <= lat; e++) begin
            @(posedge clk); #1;
            if (e == lat - 1) chk({tag, "_valid_early"}, 16'(bus.out_valid), 16'd0);
        end
        chk({tag, "_valid_on_time"}, 16'(bus.out_valid), 16'd1);
    endtask

    task automatic check_result(input string tag, input logic sgn, input int scale,
                                input logic [7:0] mant, input logic sticky,
                                input logic inf, input logic zero);
        chk({tag, "_sign"},   16'(bus.out_sign), 16'(sgn));
        chk({tag, "_scale"},  bus.out_scale, 16'(scale));
        chk({tag, "_mant"},   16'(bus.out_mant), 16'(mant));
        chk({tag, "_sticky"}, 16'(bus.out_sticky), 16'(sticky));
        chk({tag, "_inf"},    16'(bus.out_inf), 16'(inf));
        chk({tag, "_zero"},   16'(bus.out_zero), 16'(zero));
    endtask

    task automatic complete(input string tag);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 16'(bus.out_valid), 16'd0);
        chk({tag, "_ready_back"}, 16'(bus.in_ready), 16'd1);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        nrst          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_a(1'b0, 0, 0, 8'h00, 1'b0, 1'b0);
        set_b(1'b0, 0, 0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  16'(bus.in_ready), 16'd1);
        chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
        check_result("rst", 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;

        // 1.0 x 1.0: P=0x4000
        set_a(1'b0, 0, 0, 8'h80, 1'b0, 1'b0);
        set_b(1'b0, 0, 0, 8'h80, 1'b0, 1'b0);
        issue("one", LAT, 1'b0);
        check_result("one", 1'b0, 0, 8'h80, 1'b0, 1'b0, 1'b0);
        complete("one");

        // 1.5 x 1.5: P=0x9000, in_valid held through the operation
        set_a(1'b0, 0, 0, 8'hC0, 1'b0, 1'b0);
        set_b(1'b0, 0, 0, 8'hC0, 1'b0, 1'b0);
        issue("onehalf", LAT, 1'b1);
        check_result("onehalf", 1'b0, 1, 8'h90, 1'b0, 1'b0, 1'b0);
        complete("onehalf");

        // scale 10 + (-11) = -1, sign 1
        set_a(1'b1, 1, 2, 8'h80, 1'b0, 1'b0);
        set_b(1'b0, -2, 5, 8'h80, 1'b0, 1'b0);
        issue("scale", LAT, 1'b0);
        check_result("scale", 1'b1, -1, 8'h80, 1'b0, 1'b0, 1'b0);
        complete("scale");

        // 0xFF x 0x81 = 0x807F, both negative
        set_a(1'b1, 0, 0, 8'hFF, 1'b0, 1'b0);
        set_b(1'b1, 0, 0, 8'h81, 1'b0, 1'b0);
        issue("sticky", LAT, 1'b0);
        check_result("sticky", 1'b0, 1, 8'h80, 1'b1, 1'b0, 1'b0);
        complete("sticky");

        // inf x 0 -> NaR, sign forced to 0
        set_a(1'b1, 2, 1, 8'hA0, 1'b1, 1'b0);
        set_b(1'b0, 0, 0, 8'h00, 1'b0, 1'b1);
        issue("inf_zero", 1, 1'b0);
        check_result("inf_zero", 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0);
        complete("inf_zero");

        // zero x normal
        set_a(1'b0, 0, 0, 8'h00, 1'b0, 1'b1);
        set_b(1'b1, 1, 3, 8'hC0, 1'b0, 1'b0);
        issue("zero", 1, 1'b0);
        check_result("zero", 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1);
        complete("zero");

        // backpressure: 0xA0 x 0xE0 = 0x8C00, scale -1 + 1 + 1 = 1
        set_a(1'b0, -1, 7, 8'hA0, 1'b0, 1'b0);
        set_b(1'b1, 0, 1, 8'hE0, 1'b0, 1'b0);
        issue("bp", LAT, 1'b0);
        set_a(1'b0, 3, 3, 8'hFF, 1'b0, 1'b0);
        set_b(1'b0, 3, 3, 8'hFF, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_valid_held", 16'(bus.out_valid), 16'd1);
            chk("bp_in_ready",   16'(bus.in_ready), 16'd0);
            chk("bp_mant_held",  16'(bus.out_mant), 16'h8C);
        end
        check_result("bp", 1'b1, 1, 8'h8C, 1'b0, 1'b0, 1'b0);
        complete("bp");

        // reset pulse in the middle of BUSY
        set_a(1'b0, 0, 0, 8'hFF, 1'b0, 1'b0);
        set_b(1'b0, 0, 0, 8'hFF, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b0;
        #1;
        chk("rst_mid_in_ready",  16'(bus.in_ready), 16'd1);
        chk("rst_mid_out_valid", 16'(bus.out_valid), 16'd0);
        chk("rst_mid_mant",      16'(bus.out_mant), 16'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;

        // 0x90 x 0xB0 = 0x6300, no normalising shift
        set_a(1'b0, 0, 0, 8'h90, 1'b0, 1'b0);
        set_b(1'b1, 0, 0, 8'hB0, 1'b0, 1'b0);
        issue("post_rst", LAT, 1'b0);
        check_result("post_rst", 1'b1, 0, 8'hC6, 1'b0, 1'b0, 1'b0);
        complete("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
